// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Tracks the destination registers of instructions in flight in the E, M
//   and W stages, together with the cycles remaining until each result
//   exists (Tnew). From that slot state it decides, combinationally:
//     - whether the D-stage instruction must stall, and
//     - where each of its source operands is forwarded from.
//
// Ports
//   clk, reset            clock (rising edge), async active-high reset
//   D_rs, D_rt            D-stage source register indices
//   D_rs_tuse, D_rt_tuse  cycles until each source is consumed (3 = not read)
//   D_A3                  D-stage write target (0 = no write)
//   D_cal .. D_mfc0       one-hot instruction class flags
//   D_md, md_busy         mul/div-class instruction, mul/div unit busy
//   flush                 exception flush; empties E, M and W
//   stall                 freeze PC and F/D, bubble into E
//   fwd_rs_D, fwd_rt_D    operand source: 0 RF, 1 E, 2 M, 3 W
//   E_A3, E_tnew          contents of the E slot
module hazard_scoreboard #(
  parameter logic [1:0] TUSE_NONE = 2'd3,
  parameter logic [1:0] TNEW_LOAD = 2'd2,
  parameter logic [1:0] TNEW_CAL  = 2'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_rs_tuse,
  input  logic [1:0] D_rt_tuse,
  input  logic [4:0] D_A3,
  input  logic       D_cal,
  input  logic       D_load,
  input  logic       D_lui,
  input  logic       D_jump,
  input  logic       D_mfhi,
  input  logic       D_mflo,
  input  logic       D_mfc0,
  input  logic       D_md,
  input  logic       md_busy,
  input  logic       flush,
  output logic       stall,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic [4:0] E_A3,
  output logic [1:0] E_tnew
);

  logic [4:0] e_a3_q, e_a3_d, m_a3_q, m_a3_d, w_a3_q, w_a3_d;
  logic [1:0] e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d, w_tnew_q, w_tnew_d;
  logic [1:0] tnew_dec;
  logic [3:0] look_rs, look_rt;
  logic       stall_rs, stall_rt;

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Nearest matching slot for a source index: returns {tnew, code}, code 0 = no
  // match. E is checked first so that a younger writer shadows older ones.
  function automatic logic [3:0] lookup(
    input logic [4:0] s,
    input logic [4:0] ea, input logic [1:0] et,
    input logic [4:0] ma, input logic [1:0] mt,
    input logic [4:0] wa, input logic [1:0] wt
  );
    if (s == 5'd0)     return 4'b0000;
    else if (ea == s)  return {et, 2'd1};
    else if (ma == s)  return {mt, 2'd2};
    else if (wa == s)  return {wt, 2'd3};
    else               return 4'b0000;
  endfunction

  // Tnew of the D-stage instruction as it enters E. jump and everything else
  // produce their result in E already.
  always_comb begin
    tnew_dec = 2'd0;
    if (D_load | D_mfc0)
      tnew_dec = TNEW_LOAD;
    else if (D_cal | D_lui | D_mfhi | D_mflo)
      tnew_dec = TNEW_CAL;
  end

  always_comb begin
    look_rs  = lookup(D_rs, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q, w_a3_q, w_tnew_q);
    look_rt  = lookup(D_rt, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q, w_a3_q, w_tnew_q);
    stall_rs = (look_rs[1:0] != 2'd0) && (D_rs_tuse != TUSE_NONE) &&
               (look_rs[3:2] > D_rs_tuse);
    stall_rt = (look_rt[1:0] != 2'd0) && (D_rt_tuse != TUSE_NONE) &&
               (look_rt[3:2] > D_rt_tuse);
    fwd_rs_D = (look_rs[3:2] == 2'd0) ? look_rs[1:0] : 2'd0;
    fwd_rt_D = (look_rt[3:2] == 2'd0) ? look_rt[1:0] : 2'd0;
    // reset gates stall directly so it drops immediately, even for md stalls
    stall    = !reset && !flush && (stall_rs || stall_rt || (D_md && md_busy));
  end

  always_comb begin
    w_a3_d   = m_a3_q;
    w_tnew_d = sat_dec(m_tnew_q);
    m_a3_d   = e_a3_q;
    m_tnew_d = sat_dec(e_tnew_q);
    e_a3_d   = D_A3;
    e_tnew_d = tnew_dec;
    if (stall) begin
      e_a3_d   = 5'd0;
      e_tnew_d = 2'd0;
    end
    // the instruction in M is the excepting one, so nothing in flight survives
    if (flush) begin
      e_a3_d   = 5'd0;
      e_tnew_d = 2'd0;
      m_a3_d   = 5'd0;
      m_tnew_d = 2'd0;
      w_a3_d   = 5'd0;
      w_tnew_d = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_a3_q   <= 5'd0;
      e_tnew_q <= 2'd0;
      m_a3_q   <= 5'd0;
      m_tnew_q <= 2'd0;
      w_a3_q   <= 5'd0;
      w_tnew_q <= 2'd0;
    end else begin
      e_a3_q   <= e_a3_d;
      e_tnew_q <= e_tnew_d;
      m_a3_q   <= m_a3_d;
      m_tnew_q <= m_tnew_d;
      w_a3_q   <= w_a3_d;
      w_tnew_q <= w_tnew_d;
    end
  end

  assign E_A3   = e_a3_q;
  assign E_tnew = e_tnew_q;

endmodule
